// File: rtl/pipe_reg_chain_pkg.sv
// Shared helpers for the registered valid/ready delay chain.
package pipe_reg_chain_pkg;

   function automatic int occ_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready word bus used on both ends of the delay chain.
interface pipe_reg_chain_if #(
   parameter int WIDTH = 8
);

   logic             valid;
   logic [WIDTH-1:0] data;
   logic             ready;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/pipe_reg_stage.sv
// One slot of the delay chain: valid bit, payload and local ready term.
module pipe_reg_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             ready
);

   // An empty slot always takes the word above it, closing bubbles.
   assign ready = !valid | dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (ready) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= up_data;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage registered delay line with valid/ready, flush and occupancy.
module pipe_reg_chain
   import pipe_reg_chain_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   pipe_reg_chain_if.slave             up,
   pipe_reg_chain_if.master            dn,
   output logic [occ_bits(DEPTH)-1:0]  occupancy
);

   localparam int CW = occ_bits(DEPTH);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("pipe_reg_chain: DEPTH must be >= 1");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("pipe_reg_chain: WIDTH must be >= 1");
      end
   endgenerate

   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic             xin;
   logic             xout;

   assign rdy[DEPTH] = dn.ready;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         logic             uv;
         logic [WIDTH-1:0] ud;

         if (i == 0) begin : g_head
            assign uv = up.valid;
            assign ud = up.data;
         end else begin : g_body
            assign uv = v[i-1];
            assign ud = d[i-1];
         end

         pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (uv),
            .up_data  (ud),
            .dn_ready (rdy[i+1]),
            .valid    (v[i]),
            .data     (d[i]),
            .ready    (rdy[i])
         );
      end
   endgenerate

   assign up.ready = rdy[0] & !flush;
   assign dn.valid = v[DEPTH-1];
   assign dn.data  = d[DEPTH-1];

   assign xin  = up.valid & up.ready;
   assign xout = v[DEPTH-1] & dn.ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         occupancy <= occupancy + CW'(xin) - CW'(xout);
      end
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomised checks of the WIDTH=8, DEPTH=4 delay chain.
module tb_pipe_reg_chain;

   localparam logic [7:0] RV = 8'hE7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] occ;
   int         n_vec = 0;
   int         n_fail = 0;

   pipe_reg_chain_if #(.WIDTH(8)) up_if ();
   pipe_reg_chain_if #(.WIDTH(8)) dn_if ();

   pipe_reg_chain #(
      .WIDTH     (8),
      .DEPTH     (4),
      .RESET_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .up        (up_if),
      .dn        (dn_if),
      .occupancy (occ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic       mv [4];
   logic [7:0] md [4];
   logic       r [5];
   int         mcnt;
   logic       xi;
   logic       xo;

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      up_if.valid = 1'b1;
      up_if.data = 8'h5A;
      dn_if.ready = 1'b1;

      // reset holds the chain empty even with input offered
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_in_ready", up_if.ready, 1);
         check("rst_out_valid", dn_if.valid, 0);
         check("rst_out_data", dn_if.data, RV);
         check("rst_occ", occ, 0);
      end
      up_if.valid = 1'b0;
      #2 rst_n = 1'b1;
      step();

      // back-to-back stream, never stalled
      for (int c = 0; c < 20; c++) begin
         up_if.valid = (c < 16);
         up_if.data = 8'(c + 1);
         #1 check("t2_in_ready", up_if.ready, 1);
         step();
         check("t2_out_valid", dn_if.valid, (c >= 3 && c <= 18));
         if (c >= 3 && c <= 18)
            check("t2_out_data", dn_if.data, 32'(c - 2));
         if (c >= 3 && c <= 15)
            check("t2_occ", occ, 4);
      end
      check("t2_occ_end", occ, 0);

      // stall: four words fill the chain, then backpressure
      dn_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         up_if.valid = 1'b1;
         up_if.data = 8'(8'hA1 + i);
         #1 check("t3_fill_ready", up_if.ready, 1);
         step();
      end
      up_if.data = 8'hA5;
      #1;
      check("t3_full_ready", up_if.ready, 0);
      check("t3_full_occ", occ, 4);
      check("t3_full_head", dn_if.data, 8'hA1);
      for (int i = 0; i < 6; i++) begin
         up_if.valid = (i < 2);
         up_if.data = 8'(8'hA5 + i);
         dn_if.ready = 1'b1;
         #1;
         check("t3_drain_valid", dn_if.valid, 1);
         check("t3_drain_data", dn_if.data, 32'(8'hA1 + i));
         if (i < 2)
            check("t3_drain_ready", up_if.ready, 1);
         step();
      end
      check("t3_empty_valid", dn_if.valid, 0);
      check("t3_empty_occ", occ, 0);

      // bubble collapse while downstream is stalled
      dn_if.ready = 1'b0;
      up_if.valid = 1'b1;
      up_if.data = 8'h11;
      step();
      up_if.valid = 1'b0;
      step();
      step();
      up_if.valid = 1'b1;
      up_if.data = 8'h22;
      step();
      up_if.valid = 1'b0;
      step();
      step();
      check("t4_occ", occ, 2);
      check("t4_head_valid", dn_if.valid, 1);
      check("t4_head_data", dn_if.data, 8'h11);
      dn_if.ready = 1'b1;
      step();
      check("t4_next_valid", dn_if.valid, 1);
      check("t4_next_data", dn_if.data, 8'h22);
      step();
      check("t4_done_valid", dn_if.valid, 0);
      check("t4_done_occ", occ, 0);

      // flush discards words and refuses the concurrent input
      dn_if.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         up_if.valid = 1'b1;
         up_if.data = 8'(8'h31 + i);
         step();
      end
      up_if.valid = 1'b0;
      step();
      check("t5_pre_occ", occ, 3);
      check("t5_pre_data", dn_if.data, 8'h31);
      flush = 1'b1;
      up_if.valid = 1'b1;
      up_if.data = 8'h55;
      #1;
      check("t5_flush_ready", up_if.ready, 0);
      check("t5_flush_hold", dn_if.valid, 1);
      step();
      flush = 1'b0;
      dn_if.ready = 1'b1;
      up_if.valid = 1'b0;
      check("t5_post_valid", dn_if.valid, 0);
      check("t5_post_occ", occ, 0);
      up_if.valid = 1'b1;
      up_if.data = 8'h66;
      step();
      up_if.valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t5_no55", dn_if.valid, 0);
         step();
      end
      check("t5_fresh_valid", dn_if.valid, 1);
      check("t5_fresh_data", dn_if.data, 8'h66);
      step();

      // asynchronous reset with a full chain
      dn_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         up_if.valid = 1'b1;
         up_if.data = 8'(8'h71 + i);
         step();
      end
      check("t6_full_occ", occ, 4);
      up_if.data = 8'h75;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", dn_if.valid, 0);
      check("t6_rst_data", dn_if.data, RV);
      check("t6_rst_occ", occ, 0);
      check("t6_rst_ready", up_if.ready, 1);
      step();
      check("t6_rst_occ2", occ, 0);
      up_if.valid = 1'b0;
      #2 rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         mv[i] = 1'b0;
         md[i] = 8'h00;
      end
      mcnt = 0;
      for (int n = 0; n < 1000; n++) begin
         up_if.valid = 1'($urandom_range(0, 1));
         up_if.data = 8'($urandom);
         dn_if.ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 31) == 0);
         #1;
         r[4] = dn_if.ready;
         for (int i = 3; i >= 0; i--)
            r[i] = !mv[i] | r[i+1];
         check("rnd_in_ready", up_if.ready, r[0] & !flush);
         check("rnd_out_valid", dn_if.valid, mv[3]);
         check("rnd_occ", occ, mcnt);
         if (mv[3])
            check("rnd_out_data", dn_if.data, md[3]);
         step();
         xi = up_if.valid & r[0] & !flush;
         xo = mv[3] & dn_if.ready;
         if (flush) begin
            for (int i = 0; i < 4; i++)
               mv[i] = 1'b0;
            mcnt = 0;
         end else begin
            for (int i = 3; i >= 0; i--) begin
               if (r[i]) begin
                  if (i == 0) begin
                     mv[0] = up_if.valid;
                     if (up_if.valid)
                        md[0] = up_if.data;
                  end else begin
                     mv[i] = mv[i-1];
                     if (mv[i-1])
                        md[i] = md[i-1];
                  end
               end
            end
            mcnt = mcnt + int'(xi) - int'(xo);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
